serial_subtract_ctrl: RTL and testbench
=======================================

# serial_subtract_ctrl

Bit-serial subtractor controller that computes `a - b` for WIDTH-bit operands by sequencing a single 1-bit full-subtract cell, one bit per clock, LSB first. It captures the operands on a start request, runs the cell for WIDTH cycles with a registered borrow chain, then presents the difference and final borrow with a one-cycle done pulse. It is the area-minimal alternative to a ripple array of subtract cells in the arithmetic datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  `a - b` mod 2^WIDTH; held until the next accepted start
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start=1` loads `a_sh<=a` and `b_sh<=b`, clears `bor_r` and `cnt`, clears `diff`/`borrow_out`, then goes to RUN. `start=0` keeps the FSM in IDLE.
- RUN: each cycle the cell takes `a_sh[0]`, `b_sh[0]` and `bor_r`.
  - `d = a^b^bin`
  - `bout = (~a&b) | (~(a^b)&bin)`
  - `d` shifts into `diff` MSB side (right shift), so after WIDTH shifts bit 0 sits at `diff[0]`.
  - `a_sh`/`b_sh` shift right by 1; `bor_r<=bout`; `cnt++`.
  - When `cnt==WIDTH-1`, the shift is the last one: `borrow_out<=bout`, go to DONE.
- DONE: `done=1` for this cycle only. Unconditional return to IDLE. `start` is ignored in DONE.
- `start` in RUN or DONE has no effect. No queuing.
- `a`/`b` may change freely after the start cycle.
- Width rules:
  - `cnt` is `$clog2(WIDTH)` bits and never wraps.
  - `diff` is exact modulo 2^WIDTH.
  - No signed interpretation; borrow_out is the unsigned underflow flag.
- Reset (any state, including mid-RUN) takes effect at the next edge with `rst_n=0`:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow_out=0
  - shift registers, `bor_r` and `cnt` cleared
  - a partial result is discarded.

## Timing
- Start accepted at edge E0 → busy=1 from E0 through E0+WIDTH.
- done=1 in the cycle following edge E0+WIDTH, i.e. latency WIDTH+1 clocks from the accepting edge.
- Next start is accepted at the edge that ends the done cycle + 1 (IDLE required). Minimum spacing between accepted starts is WIDTH+2 clocks.
- All outputs are registered; no combinational path from inputs to outputs.
- `diff` is a partial shift value during RUN and must only be consumed when done=1 or afterwards in IDLE.

## Structure
- Shared package `arith_pkg`:
  - state enum `sub_state_t {IDLE, RUN, DONE}`
  - `localparam` for the default WIDTH
- Sub-module `full_subtract_bit`: inputs a, b, bin; outputs d, bout. Combinational, built from two half-subtract cells plus an OR for the borrows.
  - Instantiated once.
  - Reusable by a future ripple version.

## Test plan
- WIDTH=8, start with a=100, b=37 → busy for 8 cycles; done in cycle 9 after the accepting edge; diff=63, borrow_out=0.
- a=5, b=10 → diff=251 (0xFB), borrow_out=1. A following run with a=255, b=255 → diff=0, borrow_out=0, with clean clearing of the prior result.
- Edge operands:
  - a=0, b=1 → diff=255, borrow=1
  - a=128, b=0 → diff=128, borrow=0
- Pulse start again mid-RUN and during the DONE cycle with different operands → ignored; the original result is delivered; exactly one done pulse.
- Assert rst_n=0 for one edge at RUN cycle 4 → next cycle: IDLE, busy=0, diff=0, borrow_out=0, no done. A new start afterwards completes correctly.
- Random sweep (≥1000 pairs, WIDTH=8 and WIDTH=13) against a `{borrow,diff} = {1'b0,a} - {1'b0,b}` reference model. Also check the done-to-done spacing is ≥ WIDTH+2.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared types and defaults for the bit-serial arithmetic blocks
package arith_pkg;
  localparam int SUB_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;
endpackage

// File: rtl/full_subtract_bit.sv
// full_subtract_bit: combinational 1-bit full subtractor built from two half-subtract stages
module full_subtract_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: LSB-first bit-serial a-b using one full-subtract cell over WIDTH cycles
module serial_subtract_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, borrow_q, borrow_d;
  logic             cell_d, cell_bout, last;
  full_subtract_bit u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bor_q),
    .d    (cell_d),
    .bout (cell_bout)
  );
  assign last       = cnt_q == CW'(WIDTH - 1);
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  // Next-state: load on accepted start, shift one bit per RUN cycle, single DONE cycle
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    if (state_q == IDLE && start) begin
      state_d  = RUN;
      a_sh_d   = a;
      b_sh_d   = b;
      diff_d   = '0;
      cnt_d    = '0;
      bor_d    = 1'b0;
      borrow_d = 1'b0;
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      diff_d   = {cell_d, diff_q[WIDTH-1:1]};
      bor_d    = cell_bout;
      cnt_d    = last ? cnt_q : cnt_q + 1'b1;
      borrow_d = last ? cell_bout : borrow_q;
      state_d  = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
    end
  end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: directed table, corner sequences and random sweep for WIDTH 8 and 13
module tb_serial_subtract_ctrl;
  logic        clk, rst_n;
  logic        start8, busy8, done8, bor8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, busy13, done13, bor13;
  logic [12:0] a13, b13, diff13;
  int          errors = 0, checks = 0, cyc = 0, last8 = -1, last13 = -1;
  typedef struct {
    logic [7:0] a, b, d;
    logic       bo;
  } vec_t;
  vec_t tbl[8];

  serial_subtract_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
  );
  serial_subtract_ctrl #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bor13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input int w);
    return w == 8 ? done8 : done13;
  endfunction

  task automatic run(input int w, input logic [31:0] ai, input logic [31:0] bi, input bit inject,
                     output logic [31:0] d, output logic bo);
    int lat, bc;
    @(negedge clk);
    if (w == 8) begin start8 = 1'b1; a8 = ai[7:0]; b8 = bi[7:0]; end
    else begin start13 = 1'b1; a13 = ai[12:0]; b13 = bi[12:0]; end
    @(negedge clk);
    start8 = 1'b0; start13 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a13 = 13'($urandom); b13 = 13'($urandom);
    lat = 1; bc = 0;
    while (!cur_done(w) && lat <= 40) begin
      bc += int'(w == 8 ? busy8 : busy13);
      start8  = (w == 8) && inject && lat == 3;
      start13 = (w == 13) && inject && lat == 3;
      @(negedge clk);
      start8 = 1'b0; start13 = 1'b0;
      lat++;
    end
    chk("latency", lat, w + 1);
    chk("busy_cycles", bc, w);
    if (w == 8) begin
      if (last8 >= 0) chk("spacing8", 32'(cyc - last8 >= w + 2), 1);
      last8 = cyc; d = 32'(diff8); bo = bor8;
    end else begin
      if (last13 >= 0) chk("spacing13", 32'(cyc - last13 >= w + 2), 1);
      last13 = cyc; d = 32'(diff13); bo = bor13;
    end
    if (inject) begin
      start8 = (w == 8); start13 = (w == 13);
      a8 = ~ai[7:0]; b8 = 8'd3; a13 = ~ai[12:0]; b13 = 13'd3;
    end
    @(negedge clk);
    start8 = 1'b0; start13 = 1'b0;
    chk("done_one_cycle", 32'(cur_done(w)), 0);
    chk("idle_after_done", 32'(w == 8 ? busy8 : busy13), 0);
    chk("diff_held", w == 8 ? 32'(diff8) : 32'(diff13), d);
  endtask

  initial begin
    logic [31:0] d, ai, bi, mask;
    logic [32:0] r;
    logic        bo;
    int          nd;
    tbl[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    tbl[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
    tbl[2] = '{8'd255, 8'd255, 8'd0,   1'b0};
    tbl[3] = '{8'd0,   8'd1,   8'd255, 1'b1};
    tbl[4] = '{8'd128, 8'd0,   8'd128, 1'b0};
    tbl[5] = '{8'd0,   8'd255, 8'd1,   1'b1};
    tbl[6] = '{8'd255, 8'd0,   8'd255, 1'b0};
    tbl[7] = '{8'd37,  8'd100, 8'd193, 1'b1};
    rst_n = 1'b0; start8 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; a13 = '0; b13 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_borrow", 32'(bor8), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(8, 32'(tbl[i].a), 32'(tbl[i].b), 1'b0, d, bo);
      chk($sformatf("tbl%0d_diff", i), d, 32'(tbl[i].d));
      chk($sformatf("tbl%0d_borrow", i), 32'(bo), 32'(tbl[i].bo));
    end
    run(8, 32'd100, 32'd37, 1'b1, d, bo);
    chk("inject_diff", d, 63);
    chk("inject_borrow", 32'(bo), 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done8);
    end
    chk("inject_no_extra_done", nd, 0);
    chk("inject_idle", 32'(busy8), 0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd0; b8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    chk("midrst_diff", 32'(diff8), 0);
    chk("midrst_borrow", 32'(bor8), 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done8);
    end
    chk("midrst_no_done", nd, 0);
    last8 = -1;
    run(8, 32'd200, 32'd55, 1'b0, d, bo);
    chk("post_rst_diff", d, 145);
    chk("post_rst_borrow", 32'(bo), 0);
    foreach (tbl[k]) begin
      run(13, 32'd5000 + 32'(k), 32'd8191 - 32'(k * 1000), 1'b0, d, bo);
      r = {1'b0, 32'd5000 + 32'(k)} - {1'b0, 32'd8191 - 32'(k * 1000)};
      chk("w13_dir_diff", d, r[31:0] & 32'h1FFF);
      chk("w13_dir_borrow", 32'(bo), 32'(r[32]));
    end
    for (int w = 8; w <= 13; w += 5) begin
      mask = (32'd1 << w) - 1;
      for (int i = 0; i < 1000; i++) begin
        ai = $urandom & mask;
        bi = $urandom & mask;
        run(w, ai, bi, 1'b0, d, bo);
        r = {1'b0, ai} - {1'b0, bi};
        chk($sformatf("rnd%0d_diff", w), d, r[31:0] & mask);
        chk($sformatf("rnd%0d_borrow", w), 32'(bo), 32'(r[32]));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
